msu_redundant_resolver: RTL and testbench
=========================================

Name: msu_redundant_resolver

Overview:
- Converts the redundant (nr, r) word-vector produced by the MSU squaring/reduction path back to canonical, fully reduced form: result = (nr + r) mod N, with 0 <= result < N.
- Sits on the MSU output/readback side, between the squaring loop's result register and the host/readout interface.
- Works word-serially: carry-propagates first, then applies conditional modulus subtractions, so the datapath stays one word wide.

Parameters:
- WordBits, 16: bits per word element (binds to msu_pkg::WordBits).
- NumWords, 66: word elements per operand (binds to msu_pkg::NumElements).
- MaxSubs, 4: maximum committed subtractions of N before declaring error.
- TotalBits, WordBits*NumWords: derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept an operand
- nr_i  in  TotalBits  non-redundant word bits
- r_i  in  TotalBits  redundant bits, word-aligned; any bit position is legal
- modulus_i  in  TotalBits  modulus N; nonzero and < 2^TotalBits; sampled at the input handshake
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  TotalBits  canonical result
- error_o  out  1  MaxSubs exhausted; qualified by out_valid_o

Behaviour:
- Reset values (asynchronous, rst_ni=0): state IDLE; in_ready_o=1; out_valid_o=0; result_o=0; error_o=0; all internal registers 0.
- FSM states: IDLE, CARRY, SUB, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: capture nr_i, r_i, modulus_i; clear word index k, carry and commit count C; go to CARRY.
- CARRY, one word per cycle, k = 0..NumWords-1:
  - v[k] = nr[k] + r[k] + c, WordBits+1 wide.
  - Store the low WordBits into V word k; c = bit WordBits.
  - After the last word, store the final c as V's top bit (vtop); go to SUB with k=0 and borrow=0.
- SUB, one subtraction pass of NumWords cycles:
  - Per cycle: d[k] = V[k] - N[k] - b; write into shadow register D word k; b = borrow out.
  - At the pass end, the pass borrow is b_final = (vtop==0 && b==1).
  - If b_final=1: V < N; go to DONE with V unchanged.
  - Else: V <= D; vtop <= vtop - b; C++.
  - If C (after increment) == MaxSubs, go to DONE with error=1; otherwise start another pass.
- DONE:
  - out_valid_o=1; result_o=V[TotalBits-1:0]; error_o as computed.
  - Outputs hold stable until out_valid_o&&out_ready_i, then return to IDLE in the next cycle.
  - in_ready_o=0 in every state except IDLE, so there is no overlap and no input buffering.
- Latency: with the handshake at edge 0, out_valid_o rises after edge 1+NumWords*(2+C) for non-error results. For error results it rises after edge 1+NumWords*(1+MaxSubs).
- Boundary conditions:
  - Result exactly equal to N: the pass does not borrow, so the result is 0.
  - Carry-out of the last CARRY word is kept in vtop, never dropped.
  - r_i=0 is legal and behaves as a plain reduction of nr_i.
  - out_ready_i held high in DONE gives a one-cycle result pulse.
  - rst_ni low mid-operation immediately returns to the reset state; the partial result is discarded and no out_valid_o is produced.

Optional Feature:
- Macro: MSU_RESOLVER_STATS_EN.
- Defined: adds output port sub_count_o, width $clog2(MaxSubs+1), equal to C. It is valid with out_valid_o and resets to 0.
- Also adds a 32-bit saturating busy_cycles_o that counts cycles spent outside IDLE since reset.
- Undefined: neither port exists, and no counter logic is built.

Decomposition:
- msu_pkg gets:
  - the resolver_state_e enum (IDLE/CARRY/SUB/DONE);
  - constant ResolverMaxSubs;
  - a word typedef msu_word_t of WordBits.
- One natural sub-module: msu_word_addsub. It is a combinational WordBits add/subtract with carry/borrow in/out, shared between CARRY and SUB. The FSM, the V/D/N registers and the index counter stay in the top module.

Test Plan:
All scenarios use the small configuration WordBits=8, NumWords=4, MaxSubs=4, N=0x000000FB.
- nr=0x000000FA, r=0 -> result 0x000000FA, error 0, C=0; out_valid_o after edge 9.
- nr=0x000000FF, r=0x00000001 -> sum 0x100 -> result 0x00000005, C=1; out_valid_o after edge 13.
- nr=0x000000FB, r=0 -> result 0x00000000, C=1 (equal-to-modulus boundary).
- nr=0xFFFFFFFF, r=0x00000001 -> vtop=1 after CARRY; 4 commits exhaust MaxSubs -> error_o=1; out_valid_o after edge 21.
- Backpressure and reset:
  - Case 2 with out_ready_i low for 5 cycles -> result_o and out_valid_o stable; in_ready_o stays 0 until one cycle after the accept.
  - rst_ni pulsed low mid-SUB -> out_valid_o never asserts; in_ready_o=1; the next operand completes correctly.

Source files
------------

// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU datapath and its readback resolver.
package msu_pkg;

    localparam int WordBits        = 16;
    localparam int NumElements     = 66;
    localparam int ResolverMaxSubs = 4;

    typedef logic [WordBits-1:0] msu_word_t;

    typedef enum logic [1:0] {
        IDLE,
        CARRY,
        SUB,
        DONE
    } resolver_state_e;

endpackage

// File: rtl/msu_word_addsub.sv
// One-word adder/subtractor with carry (add) or borrow (subtract) in and out.
// The resolver uses it for carry propagation and for trial modulus subtraction.
module msu_word_addsub #(
    parameter int WordBits = msu_pkg::WordBits
) (
    input  logic [WordBits-1:0] a,
    input  logic [WordBits-1:0] b,
    input  logic                carry_in,
    input  logic                sub,
    output logic [WordBits-1:0] y,
    output logic                carry_out
);

    logic [WordBits:0] acc;

    // One bit wider than a word: the top bit is the carry on add and the borrow on subtract
    always_comb begin
        if (sub) begin
            acc = {1'b0, a} - {1'b0, b} - {{WordBits{1'b0}}, carry_in};
        end else begin
            acc = {1'b0, a} + {1'b0, b} + {{WordBits{1'b0}}, carry_in};
        end
    end

    assign y         = acc[WordBits-1:0];
    assign carry_out = acc[WordBits];

endmodule

// File: rtl/msu_redundant_resolver.sv
// Resolves a redundant (nr, r) operand into (nr + r) mod N, one word per cycle.
// The CARRY phase folds r into nr, keeping the final carry in vtop. It takes one
// extra cycle after the last word to latch vtop. Each SUB pass then trial-subtracts
// N into the shadow D and commits D only when the pass does not borrow.
// Optional build macro MSU_RESOLVER_STATS_EN adds sub_count_o and busy_cycles_o.
module msu_redundant_resolver #(
    parameter  int WordBits  = msu_pkg::WordBits,
    parameter  int NumWords  = msu_pkg::NumElements,
    parameter  int MaxSubs   = msu_pkg::ResolverMaxSubs,
    localparam int TotalBits = WordBits * NumWords
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [TotalBits-1:0] nr_i,
    input  logic [TotalBits-1:0] r_i,
    input  logic [TotalBits-1:0] modulus_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [TotalBits-1:0] result_o,
    output logic                 error_o
`ifdef MSU_RESOLVER_STATS_EN
    ,
    output logic [$clog2(MaxSubs+1)-1:0] sub_count_o,
    output logic [31:0]                  busy_cycles_o
`endif
);

    import msu_pkg::*;

    localparam int IdxBits = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int CntBits = $clog2(MaxSubs + 1);
    localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NumWords - 1);
    localparam logic [CntBits-1:0] LastCnt = CntBits'(MaxSubs - 1);

    resolver_state_e state, state_next;

    // v: working value; d: holds r during CARRY, then the trial difference during SUB
    logic [NumWords-1:0][WordBits-1:0] v, d, n, d_next;
    logic                              vtop, cy, flush, err;
    logic [IdxBits-1:0]                k;
    logic [CntBits-1:0]                cnt;
    logic [WordBits-1:0]               au_b, au_y;
    logic                              au_cout;
    logic                              last_word, pass_borrow, subs_full;

    assign au_b        = (state == SUB) ? n[k] : d[k];
    assign last_word   = (k == LastIdx);
    assign pass_borrow = ~vtop & au_cout;
    assign subs_full   = (cnt == LastCnt);

    msu_word_addsub #(
        .WordBits(WordBits)
    ) u_addsub (
        .a        (v[k]),
        .b        (au_b),
        .carry_in (cy),
        .sub      (state == SUB),
        .y        (au_y),
        .carry_out(au_cout)
    );

    // Full trial difference including the word being produced this cycle
    always_comb begin
        d_next    = d;
        d_next[k] = au_y;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a SUB pass ends in DONE on a pass borrow or on the last allowed commit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid_i) state_next = CARRY;
            CARRY:   if (flush) state_next = SUB;
            SUB:     if (last_word && (pass_borrow || subs_full)) state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word-serial datapath: capture, carry propagation, trial subtraction and commit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v     <= '0;
            d     <= '0;
            n     <= '0;
            vtop  <= 1'b0;
            cy    <= 1'b0;
            flush <= 1'b0;
            err   <= 1'b0;
            k     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        v     <= nr_i;
                        d     <= r_i;
                        n     <= modulus_i;
                        vtop  <= 1'b0;
                        cy    <= 1'b0;
                        flush <= 1'b0;
                        err   <= 1'b0;
                        k     <= '0;
                        cnt   <= '0;
                    end
                end
                CARRY: begin
                    if (flush) begin
                        vtop  <= cy;
                        cy    <= 1'b0;
                        k     <= '0;
                        flush <= 1'b0;
                    end else begin
                        v[k] <= au_y;
                        cy   <= au_cout;
                        if (last_word) begin
                            flush <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                SUB: begin
                    d[k] <= au_y;
                    cy   <= au_cout;
                    if (last_word) begin
                        k  <= '0;
                        cy <= 1'b0;
                        if (!pass_borrow) begin
                            v    <= d_next;
                            vtop <= vtop & ~au_cout;
                            cnt  <= cnt + 1'b1;
                            if (subs_full) begin
                                err <= 1'b1;
                            end
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign result_o    = out_valid_o ? v : '0;
    assign error_o     = out_valid_o & err;

`ifdef MSU_RESOLVER_STATS_EN
    logic [31:0] busy;

    // Saturating count of cycles spent outside IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else if ((state != IDLE) && (busy != 32'hFFFF_FFFF)) begin
            busy <= busy + 32'd1;
        end
    end

    assign sub_count_o   = cnt;
    assign busy_cycles_o = busy;
`endif

endmodule

// File: tb/tb_msu_redundant_resolver.sv
// Bench for msu_redundant_resolver in the small configuration (8-bit words, 4 words).
// Honours MSU_RESOLVER_STATS_EN to connect and check the optional ports.
module tb_msu_redundant_resolver;

    localparam int WB = 8;
    localparam int NW = 4;
    localparam int MS = 4;
    localparam int TB = WB * NW;
    localparam int CW = $clog2(MS + 1);
    localparam logic [31:0] NMOD = 32'h0000_00FB;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TB-1:0] nr = '0;
    logic [TB-1:0] r = '0;
    logic [TB-1:0] modulus = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TB-1:0] result;
    logic          error;
`ifdef MSU_RESOLVER_STATS_EN
    logic [CW-1:0] sub_count;
    logic [31:0]   busy_cycles;
    int            seen_sc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    msu_redundant_resolver #(
        .WordBits(WB),
        .NumWords(NW),
        .MaxSubs (MS)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .nr_i       (nr),
        .r_i        (r),
        .modulus_i  (modulus),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .error_o    (error)
`ifdef MSU_RESOLVER_STATS_EN
        ,
        .sub_count_o  (sub_count),
        .busy_cycles_o(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: add, then subtract N while the value is >= N, at most MS times.
    // Reaching MS commits is an error regardless of the remaining value.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                                  output logic [31:0] res, output logic er, output int c,
                                  output int lat);
        logic [63:0] s;
        logic [63:0] mm;
        s  = {32'd0, a} + {32'd0, b};
        mm = {32'd0, m};
        c  = 0;
        for (int i = 0; i < MS; i++) begin
            if (s < mm) break;
            s = s - mm;
            c++;
        end
        er  = (c == MS);
        res = s[31:0];
        lat = er ? 1 + NW * (1 + MS) : 1 + NW * (2 + c);
    endfunction

    // Handshake at edge 0, count edges until out_valid, optionally stall, then accept
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m, input int hold,
                          output logic [31:0] res, output logic er, output int lat);
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
        nr       = a;
        r        = b;
        modulus  = m;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        er  = error;
`ifdef MSU_RESOLVER_STATS_EN
        seen_sc = int'(sub_count);
`endif
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid not seen within %0d cycles", tag, lat);
            out_ready = 1'b1;
            return;
        end
        check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_result"}, result, res);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, out_valid, 1'b0);
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    typedef struct {
        logic [31:0] nr;
        logic [31:0] r;
        logic [31:0] res;
        logic        err;
        int          c;
        int          lat;
        int          hold;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] got_res;
    logic        got_err;
    int          got_lat;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_c;
    int          exp_lat;
    logic [31:0] ra, rb, rm;
    logic        saw_valid;

    initial begin
        vecs[0] = '{32'h0000_00FA, 32'h0000_0000, 32'h0000_00FA, 1'b0, 0,  9, 0};
        vecs[1] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0005, 1'b0, 1, 13, 5};
        vecs[2] = '{32'h0000_00FB, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 13, 0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FC14, 1'b1, 4, 21, 0};
        vecs[4] = '{32'h0000_01F6, 32'h0000_0000, 32'h0000_0000, 1'b0, 2, 17, 0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FC14, 1'b1, 4, 21, 2};
        vecs[6] = '{32'h0000_0301, 32'h0000_0000, 32'h0000_0010, 1'b0, 3, 21, 0};
        vecs[7] = '{32'h0000_0000, 32'h0000_01FC, 32'h0000_0006, 1'b0, 2, 17, 0};

        // Reset state
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_error", error, 1'b0);
`ifdef MSU_RESOLVER_STATS_EN
        check("rst_sub_count", sub_count, '0);
        check("rst_busy", busy_cycles, 32'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].nr, vecs[i].r, NMOD, vecs[i].hold,
                   got_res, got_err, got_lat);
            check($sformatf("vec%0d_result", i), got_res, vecs[i].res);
            check($sformatf("vec%0d_error", i), got_err, vecs[i].err);
            check($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
`ifdef MSU_RESOLVER_STATS_EN
            check($sformatf("vec%0d_sub_count", i), seen_sc, vecs[i].c);
`endif
        end

        // Asynchronous reset in the middle of a SUB pass
        nr       = 32'h0000_00FF;
        r        = 32'h0000_0001;
        modulus  = NMOD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_result", result, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        saw_valid = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_valid", saw_valid, 1'b0);
        check("midrst_in_ready_after", in_ready, 1'b1);
        run_op("post_rst", 32'h0000_00FF, 32'h0000_0001, NMOD, 0, got_res, got_err, got_lat);
        check("post_rst_result", got_res, 32'h0000_0005);
        check("post_rst_error", got_err, 1'b0);
        check("post_rst_latency", got_lat, 13);

        // Randomized operands against the reference model
        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 1023));
            rb = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            rm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 255)) : (32'($urandom) | 32'h1);
            model(ra, rb, rm, exp_res, exp_err, exp_c, exp_lat);
            run_op($sformatf("rnd%0d", t), ra, rb, rm, $urandom_range(0, 2),
                   got_res, got_err, got_lat);
            check($sformatf("rnd%0d_result", t), got_res, exp_res);
            check($sformatf("rnd%0d_error", t), got_err, exp_err);
            check($sformatf("rnd%0d_latency", t), got_lat, exp_lat);
`ifdef MSU_RESOLVER_STATS_EN
            check($sformatf("rnd%0d_sub_count", t), seen_sc, exp_c);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
